trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_pkg.sv | 29 ++
 rtl/trap_prio.sv | 67 ++++++
 rtl/trap_ctrl.sv | 122 ++++++++++++
 tb/tb_trap_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared trap-controller definitions: FSM states, cause codes and mcause layout.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TAKE,
        ST_RET,
        ST_SETTLE
    } trap_state_e;

    localparam int unsigned CODE_W         = 4;
    localparam int unsigned MCAUSE_INT_BIT = 31;

    typedef logic [CODE_W-1:0] cause_t;

    localparam cause_t CAUSE_ILLEGAL = 4'd2;
    localparam cause_t CAUSE_ECALL_M = 4'd11;
    localparam cause_t CAUSE_MTI     = 4'd7;
    localparam cause_t CAUSE_MEI     = 4'd11;

    function automatic logic [31:0] make_mcause(input logic is_int, input cause_t code);
        logic [31:0] m;
        m                 = '0;
        m[MCAUSE_INT_BIT] = is_int;
        m[CODE_W-1:0]     = code;
        return m;
    endfunction

endpackage

// File: rtl/trap_prio.sv
// Combinational event prioritisation for the execute stage and trap vector computation.
module trap_prio
    import trap_pkg::*;
(
    input  logic        en,
    input  logic        valid_s2,
    input  logic        illegal_i,
    input  logic        ecall_i,
    input  logic        mret_i,
    input  logic        br_taken,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mie_mtie,
    input  logic [31:0] mtvec_i,
    input  logic        vec_int,
    input  cause_t      vec_code,
    output logic        take_trap,
    output logic        take_mret,
    output logic        trap_int,
    output cause_t      trap_code,
    output logic [31:0] vec_pc
);

    logic        ev_ok;
    logic        irq_ok;
    logic [31:0] base;

    always_comb begin
        take_trap = 1'b0;
        take_mret = 1'b0;
        trap_int  = 1'b0;
        trap_code = '0;
        ev_ok     = en && valid_s2;
        // Interrupts must not split a redirecting branch from its target fetch.
        irq_ok    = ev_ok && mstatus_mie && !br_taken;

        if (ev_ok && illegal_i) begin
            take_trap = 1'b1;
            trap_code = CAUSE_ILLEGAL;
        end else if (ev_ok && ecall_i) begin
            take_trap = 1'b1;
            trap_code = CAUSE_ECALL_M;
        end else if (ev_ok && mret_i) begin
            take_mret = 1'b1;
        end else if (irq_ok && irq_ext && mie_meie) begin
            take_trap = 1'b1;
            trap_int  = 1'b1;
            trap_code = CAUSE_MEI;
        end else if (irq_ok && irq_timer && mie_mtie) begin
            take_trap = 1'b1;
            trap_int  = 1'b1;
            trap_code = CAUSE_MTI;
        end
    end

    always_comb begin
        base = {mtvec_i[31:2], 2'b00};
        if (vec_int && (mtvec_i[1:0] == 2'b01)) begin
            vec_pc = base + {26'b0, vec_code, 2'b00};
        end else begin
            vec_pc = base;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/interrupt controller: accepts execute-stage events, captures mepc/mcause, redirects fetch.
module trap_ctrl
    import trap_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_s2,
    input  logic [31:0] pc_s2,
    input  logic        illegal_i,
    input  logic        ecall_i,
    input  logic        mret_i,
    input  logic        br_taken,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mie_mtie,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        kill_s2,
    output logic        flush_s1,
    output logic        redirect_o,
    output logic [31:0] redirect_pc,
    output logic        csr_trap_we,
    output logic [31:0] mepc_o,
    output logic [31:0] mcause_o,
    output logic        mret_o
);

    trap_state_e state_q, state_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    logic        take_trap;
    logic        take_mret;
    logic        trap_int;
    cause_t      trap_code;
    logic [31:0] vec_pc;

    // Gating on rst_n keeps the IDLE decode quiet while reset is held.
    trap_prio u_prio (
        .en          (rst_n && (state_q == ST_IDLE)),
        .valid_s2    (valid_s2),
        .illegal_i   (illegal_i),
        .ecall_i     (ecall_i),
        .mret_i      (mret_i),
        .br_taken    (br_taken),
        .irq_ext     (irq_ext),
        .irq_timer   (irq_timer),
        .mstatus_mie (mstatus_mie),
        .mie_meie    (mie_meie),
        .mie_mtie    (mie_mtie),
        .mtvec_i     (mtvec_i),
        .vec_int     (mcause_q[MCAUSE_INT_BIT]),
        .vec_code    (mcause_q[CODE_W-1:0]),
        .take_trap   (take_trap),
        .take_mret   (take_mret),
        .trap_int    (trap_int),
        .trap_code   (trap_code),
        .vec_pc      (vec_pc)
    );

    always_comb begin
        state_d     = state_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        kill_s2     = 1'b0;
        flush_s1    = 1'b0;
        redirect_o  = 1'b0;
        redirect_pc = '0;
        csr_trap_we = 1'b0;
        mret_o      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (take_trap) begin
                    kill_s2  = 1'b1;
                    flush_s1 = 1'b1;
                    mepc_d   = pc_s2;
                    mcause_d = make_mcause(trap_int, trap_code);
                    state_d  = ST_TAKE;
                end else if (take_mret) begin
                    flush_s1 = 1'b1;
                    state_d  = ST_RET;
                end
            end
            ST_TAKE: begin
                redirect_o  = 1'b1;
                redirect_pc = vec_pc;
                csr_trap_we = 1'b1;
                flush_s1    = 1'b1;
                state_d     = ST_SETTLE;
            end
            ST_RET: begin
                redirect_o  = 1'b1;
                redirect_pc = mepc_i & ~32'h1;
                mret_o      = 1'b1;
                flush_s1    = 1'b1;
                state_d     = ST_SETTLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            state_q  <= state_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

    assign mepc_o   = mepc_q;
    assign mcause_o = mcause_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl: exceptions, interrupts, mret, deferral and reset abort.
module tb_trap_ctrl;

    logic        clk;
    logic        rst_n;
    logic        valid_s2;
    logic [31:0] pc_s2;
    logic        illegal_i, ecall_i, mret_i, br_taken;
    logic        irq_ext, irq_timer;
    logic        mstatus_mie, mie_meie, mie_mtie;
    logic [31:0] mtvec_i, mepc_i;
    logic        kill_s2, flush_s1, redirect_o, csr_trap_we, mret_o;
    logic [31:0] redirect_pc, mepc_o, mcause_o;

    int checks;
    int failures;

    trap_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_s2    (valid_s2),
        .pc_s2       (pc_s2),
        .illegal_i   (illegal_i),
        .ecall_i     (ecall_i),
        .mret_i      (mret_i),
        .br_taken    (br_taken),
        .irq_ext     (irq_ext),
        .irq_timer   (irq_timer),
        .mstatus_mie (mstatus_mie),
        .mie_meie    (mie_meie),
        .mie_mtie    (mie_mtie),
        .mtvec_i     (mtvec_i),
        .mepc_i      (mepc_i),
        .kill_s2     (kill_s2),
        .flush_s1    (flush_s1),
        .redirect_o  (redirect_o),
        .redirect_pc (redirect_pc),
        .csr_trap_we (csr_trap_we),
        .mepc_o      (mepc_o),
        .mcause_o    (mcause_o),
        .mret_o      (mret_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse/strobe outputs packed as {kill, flush, redirect, csr_we, mret}.
    function automatic logic [31:0] strobes();
        return {27'b0, kill_s2, flush_s1, redirect_o, csr_trap_we, mret_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        valid_s2  = 1'b0;
        illegal_i = 1'b0;
        ecall_i   = 1'b0;
        mret_i    = 1'b0;
        br_taken  = 1'b0;
        irq_ext   = 1'b0;
        irq_timer = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        clr();
        pc_s2       = '0;
        mtvec_i     = '0;
        mepc_i      = '0;
        mstatus_mie = 1'b0;
        mie_meie    = 1'b0;
        mie_mtie    = 1'b0;
        rst_n       = 1'b0;

        // Reset: an event on the inputs must not produce strobes.
        valid_s2 = 1'b1;
        ecall_i  = 1'b1;
        pc_s2    = 32'h100;
        step();
        step();
        #1;
        chk("rst_strobes", strobes(), 32'h0);
        chk("rst_mepc", mepc_o, 32'h0);
        chk("rst_mcause", mcause_o, 32'h0);
        clr();
        rst_n = 1'b1;

        // ecall ignored while valid_s2=0
        step();
        ecall_i = 1'b1;
        #1;
        chk("ecall_invalid", strobes(), 32'h0);
        clr();

        // ecall at 0x100, mtvec 0x200
        step();
        valid_s2 = 1'b1;
        ecall_i  = 1'b1;
        pc_s2    = 32'h100;
        mtvec_i  = 32'h200;
        #1;
        chk("ecall_N_strobes", strobes(), 32'h18);
        step();
        clr();
        #1;
        chk("ecall_take_strobes", strobes(), 32'h0E);
        chk("ecall_redirect_pc", redirect_pc, 32'h200);
        chk("ecall_mepc", mepc_o, 32'h100);
        chk("ecall_mcause", mcause_o, 32'h0000000B);
        step();
        valid_s2 = 1'b1;
        ecall_i  = 1'b1;
        #1;
        chk("ecall_settle", strobes(), 32'h0);
        step();
        clr();

        // Timer interrupt, vectored mtvec
        mstatus_mie = 1'b1;
        mie_mtie    = 1'b1;
        mtvec_i     = 32'h201;
        pc_s2       = 32'h40;
        valid_s2    = 1'b1;
        irq_timer   = 1'b1;
        #1;
        chk("mti_N_strobes", strobes(), 32'h18);
        step();
        clr();
        #1;
        chk("mti_take_strobes", strobes(), 32'h0E);
        chk("mti_redirect_pc", redirect_pc, 32'h21C);
        chk("mti_mcause", mcause_o, 32'h80000007);
        chk("mti_mepc", mepc_o, 32'h40);
        step();
        step();

        // ext+timer deferred by br_taken, then ext wins
        mie_meie  = 1'b1;
        pc_s2     = 32'h80;
        valid_s2  = 1'b1;
        irq_ext   = 1'b1;
        irq_timer = 1'b1;
        br_taken  = 1'b1;
        #1;
        chk("irq_br_defer", strobes(), 32'h0);
        step();
        chk("irq_br_mcause_hold", mcause_o, 32'h80000007);
        br_taken = 1'b0;
        #1;
        chk("irq_after_br_N", strobes(), 32'h18);
        step();
        clr();
        #1;
        chk("mei_mcause", mcause_o, 32'h8000000B);
        chk("mei_redirect_pc", redirect_pc, 32'h22C);
        chk("mei_mepc", mepc_o, 32'h80);
        step();
        step();

        // mret with odd mepc
        mepc_i   = 32'h105;
        valid_s2 = 1'b1;
        mret_i   = 1'b1;
        #1;
        chk("mret_N_strobes", strobes(), 32'h08);
        step();
        clr();
        #1;
        chk("mret_ret_strobes", strobes(), 32'h0D);
        chk("mret_redirect_pc", redirect_pc, 32'h104);
        chk("mret_mcause_hold", mcause_o, 32'h8000000B);
        chk("mret_mepc_hold", mepc_o, 32'h80);
        step();
        valid_s2 = 1'b1;
        irq_ext  = 1'b1;
        #1;
        chk("mret_settle_irq", strobes(), 32'h0);
        step();
        clr();
        #1;
        chk("mret_post_settle", strobes(), 32'h0);

        // illegal + ecall -> illegal; exception ignores vectored mode
        step();
        valid_s2  = 1'b1;
        illegal_i = 1'b1;
        ecall_i   = 1'b1;
        pc_s2     = 32'h300;
        #1;
        chk("ill_N_strobes", strobes(), 32'h18);
        step();
        clr();
        #1;
        chk("ill_mcause", mcause_o, 32'h00000002);
        chk("ill_redirect_pc", redirect_pc, 32'h200);
        chk("ill_mepc", mepc_o, 32'h300);
        step();
        step();

        // Global MIE clear masks interrupts
        mstatus_mie = 1'b0;
        valid_s2    = 1'b1;
        irq_ext     = 1'b1;
        #1;
        chk("mie0_no_accept", strobes(), 32'h0);
        step();
        #1;
        chk("mie0_still_idle", strobes(), 32'h0);
        chk("mie0_mcause_hold", mcause_o, 32'h00000002);
        clr();

        // Reset during TAKE aborts the trap
        step();
        valid_s2 = 1'b1;
        ecall_i  = 1'b1;
        pc_s2    = 32'h500;
        step();
        clr();
        #1;
        chk("rst_pre_take", strobes(), 32'h0E);
        rst_n = 1'b0;
        #1;
        chk("rst_take_strobes", strobes(), 32'h0);
        chk("rst_take_mepc", mepc_o, 32'h0);
        chk("rst_take_mcause", mcause_o, 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_release_0", strobes(), 32'h0);
        step();
        chk("rst_release_1", strobes(), 32'h0);
        step();
        chk("rst_release_2", strobes(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
